// File: rtl/dco_tune_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dco_tune_pkg
// Brief    : Shared types and constants for the DCO tuning-word encoder.
// Revision : 1.0 - initial release
// ============================================================================
package dco_tune_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_IDLE  = 2'd2,
        ST_APPLY = 2'd3
    } state_t;

    localparam int c_l_max  = 25;
    localparam int c_dim_l  = 5;
    localparam int c_dim_ms = 16;

endpackage
`default_nettype wire

// File: rtl/cap_bank_enc.sv
`default_nettype none
// ============================================================================
// Module   : cap_bank_enc
// Brief    : Count to rall/row/col select pattern for a D x D capacitor bank.
// Revision : 1.0 - initial release
// ============================================================================
module cap_bank_enc #(
    parameter int D  = 16,
    parameter int CW = 8
) (
    input  logic [CW-1:0] i_count,
    output logic [D-1:0]  o_rall,
    output logic [D-1:0]  o_row,
    output logic [D-1:0]  o_col
);

    logic [CW-1:0] w_q;
    logic [CW-1:0] w_r;

    assign w_q = i_count / CW'(D);
    assign w_r = i_count % CW'(D);

    // Full rows below q, a partial row q with r columns; no partial row once q reaches D.
    for (genvar i = 0; i < D; i++) begin : g_cell
        assign o_rall[i] = (w_q > CW'(i));
        assign o_row[i]  = (w_q == CW'(i));
        assign o_col[i]  = (w_r > CW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/dco_tune_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dco_tune_encoder
// Brief    : DCO capacitor-bank front end: power-up sequencing, tuning-word
//            handshake and L/M/S bank thermometer encoding.
//            Optional S-bank sigma-delta dithering under `DCO_DITHER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dco_tune_encoder
    import dco_tune_pkg::*;
#(
    parameter int         WAKE_CYCLES   = 16,
    parameter logic [1:0] OSC_GAIN_INIT = 2'd2,
    parameter int         FRAC_W        = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tw_valid,
    output logic              tw_ready,
    input  logic [4:0]        tw_l,
    input  logic [7:0]        tw_m,
    input  logic [7:0]        tw_s,
    input  logic [FRAC_W-1:0] tw_frac,
    output logic              pd,
    output logic [1:0]        osc_gain,
    output logic [4:0]        c_l_rall,
    output logic [4:0]        c_l_row,
    output logic [4:0]        c_l_col,
    output logic [15:0]       c_m_rall,
    output logic [15:0]       c_m_row,
    output logic [15:0]       c_m_col,
    output logic [15:0]       c_s_rall,
    output logic [15:0]       c_s_row,
    output logic [15:0]       c_s_col,
    output logic              busy
);

    localparam int c_wcw = $clog2(WAKE_CYCLES + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_wcw-1:0] r_wake_cnt;
    logic             w_wake_done;
    logic             w_accept;
    logic             w_s_upd;

    logic [4:0] r_l, w_l_clamp;
    logic [7:0] r_m, r_s, w_s_eff;

    logic [4:0]  w_l_rall, w_l_row, w_l_col;
    logic [15:0] w_m_rall, w_m_row, w_m_col;
    logic [15:0] w_s_rall, w_s_row, w_s_col;

    logic [4:0]  r_l_rall, r_l_row, r_l_col;
    logic [15:0] r_m_rall, r_m_row, r_m_col;
    logic [15:0] r_s_rall, r_s_row, r_s_col;

    assign w_wake_done = (r_wake_cnt == c_wcw'(WAKE_CYCLES - 1));
    assign w_accept    = tw_valid && en && (r_state == ST_IDLE);
    assign w_l_clamp   = (tw_l > 5'(c_l_max)) ? 5'(c_l_max) : tw_l;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_OFF;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        pd          = 1'b1;
        osc_gain    = 2'd0;
        tw_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (en) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                pd       = 1'b0;
                osc_gain = OSC_GAIN_INIT;
                busy     = 1'b1;
                if (w_wake_done) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                pd       = 1'b0;
                osc_gain = OSC_GAIN_INIT;
                tw_ready = 1'b1;
                if (tw_valid) w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                pd          = 1'b0;
                osc_gain    = OSC_GAIN_INIT;
                busy        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_OFF;
        endcase
        if (!en) w_state_nxt = ST_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAKE)) r_wake_cnt <= '0;
        else if (!w_wake_done)           r_wake_cnt <= r_wake_cnt + c_wcw'(1);
    end

    // Dropping en discards any word latched but not yet applied.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_l <= '0;
            r_m <= '0;
            r_s <= '0;
        end else if (w_accept) begin
            r_l <= w_l_clamp;
            r_m <= tw_m;
            r_s <= tw_s;
        end
    end

`ifdef DCO_DITHER_EN
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_acc_sum;
    logic [8:0]        w_s_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, tw_frac};
    assign w_s_sum   = {1'b0, r_s} + 9'(w_acc_sum[FRAC_W]);
    assign w_s_eff   = w_s_sum[8] ? 8'hFF : w_s_sum[7:0];
    assign w_s_upd   = (r_state == ST_IDLE) || (r_state == ST_APPLY);

    always_ff @(posedge clk) begin
        if (rst || !en || w_accept) r_acc <= '0;
        else if (w_s_upd)           r_acc <= w_acc_sum[FRAC_W-1:0];
    end
`else
    logic w_unused_frac;

    assign w_unused_frac = ^tw_frac;
    assign w_s_eff       = r_s;
    assign w_s_upd       = (r_state == ST_APPLY);
`endif

    cap_bank_enc #(.D(c_dim_l), .CW(5)) u_enc_l (
        .i_count (r_l),
        .o_rall  (w_l_rall),
        .o_row   (w_l_row),
        .o_col   (w_l_col)
    );

    cap_bank_enc #(.D(c_dim_ms), .CW(8)) u_enc_m (
        .i_count (r_m),
        .o_rall  (w_m_rall),
        .o_row   (w_m_row),
        .o_col   (w_m_col)
    );

    cap_bank_enc #(.D(c_dim_ms), .CW(8)) u_enc_s (
        .i_count (w_s_eff),
        .o_rall  (w_s_rall),
        .o_row   (w_s_row),
        .o_col   (w_s_col)
    );

    // Count 0 is encoded as row[0]=1 with everything else clear.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_l_rall <= '0; r_l_row <= 5'h01;  r_l_col <= '0;
            r_m_rall <= '0; r_m_row <= 16'h1;  r_m_col <= '0;
        end else if (r_state == ST_APPLY) begin
            r_l_rall <= w_l_rall; r_l_row <= w_l_row; r_l_col <= w_l_col;
            r_m_rall <= w_m_rall; r_m_row <= w_m_row; r_m_col <= w_m_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_s_rall <= '0; r_s_row <= 16'h1; r_s_col <= '0;
        end else if (w_s_upd) begin
            r_s_rall <= w_s_rall; r_s_row <= w_s_row; r_s_col <= w_s_col;
        end
    end

    assign c_l_rall = r_l_rall;
    assign c_l_row  = r_l_row;
    assign c_l_col  = r_l_col;
    assign c_m_rall = r_m_rall;
    assign c_m_row  = r_m_row;
    assign c_m_col  = r_m_col;
    assign c_s_rall = r_s_rall;
    assign c_s_row  = r_s_row;
    assign c_s_col  = r_s_col;

endmodule
`default_nettype wire
